dds_freq_sweep: RTL and testbench
=================================

// Module: dds_freq_sweep
// PURPOSE
//  Frequency-ramp generator feeding dds_slave: produces tuning word freq (Freq[Hz]*2^32/F_clk)
//  and one-cycle sync strobe for dds_slave.freq / dds_slave.synch. Runs in the DDS clock domain.
//  Register-programmable sweep (min/max/step/interval/mode) with start/stop handshake.
// PARAMETERS
//  FW            32             tuning-word width
//  TW            32             interval counter width
//  DEF_FREQ_MIN  32'h0020C49B   freq reset value (100 kHz @ 200 MHz)
// PORTS
//  clk        in   1   DDS clock
//  reset      in   1   synchronous, active-high
//  start      in   1   pulse; begins sweep when idle
//  stop       in   1   pulse; aborts sweep
//  mode       in   2   sweep_mode_t: SW_SINGLE=0, SW_WRAP=1, SW_BOUNCE=2 (3 treated as SINGLE)
//  freq_min   in   FW  lower bound
//  freq_max   in   FW  upper bound
//  freq_step  in   FW  increment per update
//  interval   in   TW  clocks between updates; 0 treated as 1
//  freq       out  FW  current tuning word to dds_slave
//  sync       out  1   1-cycle pulse coincident with every freq change
//  active     out  1   1 while sweeping
//  ready      out  1   1-cycle pulse at sweep end / stop / reject
//  dir        out  1   0 = up, 1 = down
//  err        out  1   sticky: start rejected (freq_min > freq_max); cleared by next accepted start
// BEHAVIOUR
//  Reset: state IDLE, freq=DEF_FREQ_MIN, sync=0, active=0, ready=0, dir=0, err=0.
//  FSM: IDLE -> RAMP -> DONE -> IDLE.
//  IDLE: start sampled high -> shadow mode/min/max/step/interval; next cycle freq=min,
//   sync=1, active=1, dir=0, cnt=interval_eff-1, state RAMP. Inputs ignored after shadowing.
//  start with freq_min>freq_max -> err=1, ready pulse next cycle, freq unchanged, stay IDLE.
//  RAMP: cnt decrements each clk; at cnt==0 update freq, pulse sync, reload cnt.
//   up:   nxt = freq + inc computed FW+1 bits; if nxt > max (incl. carry):
//         SINGLE -> freq=max, sync, go DONE; WRAP -> freq=min; BOUNCE -> freq=max, dir=1.
//   down: nxt = freq - inc FW+1 bits; if borrow or nxt < min: freq=min, dir=0.
//   nxt == max (or == min going down) is in range: no turnaround that update.
//   step==0: freq constant, sync still pulses every interval; SINGLE ends only by stop.
//  DONE: ready=1 one cycle, active=0, -> IDLE; freq holds last value.
//  stop in RAMP: next cycle ready=1, active=0, IDLE, freq holds, no sync.
//  stop and start same cycle: stop wins (start ignored). start while active: ignored.
//  stop in IDLE: no effect. reset mid-sweep: immediate return to reset values.
//  Latency start->first sync: 1 clk; update period: interval_eff clks.
// CONFIGURATION
//  SWEEP_PROP_STEP_EN defined: inc = freq_step + {16'h0, freq[FW-1:16]} (proportional,
//   log-like sweep; FW must be 32 when defined). Undefined: inc = freq_step (linear).
// STRUCTURE
//  llrf_afe_package: sweep_mode_t enum, sweep_state_t enum (ST_IDLE/ST_RAMP/ST_DONE),
//   DDS_FREQ_100K/DDS_FREQ_30M constants. Single module, no sub-modules; interval counter inline.
// TESTING
//  1 reset: assert reset 3 clks -> freq=32'h0020C49B, sync/active/ready/err=0.
//  2 SINGLE min=100,max=130,step=10,interval=4: start -> freq 100,110,120,130 every 4 clks,
//    sync each; ready pulse 1 clk after 130, active=0.
//  3 WRAP min=0,max=25,step=10,interval=1 -> 0,10,20,0,10... ; BOUNCE same -> 0,10,20,25,15,5,0,10.
//  4 overflow: min=32'hFFFFFFF0,max=32'hFFFFFFFF,step=32'h20,SINGLE -> freq=32'hFFFFFFFF, ready.
//  5 stop mid-RAMP at freq=120 -> next clk ready=1, active=0, freq stays 120; start+stop same clk
//    in IDLE -> no sweep; min=200>max=100 start -> err=1, ready pulse, freq unchanged.
//  6 SWEEP_PROP_STEP_EN, min=32'h00010000, step=0, interval=1 -> freq 0x10000,0x10001,0x10002.

Source files
------------

// File: rtl/dds_freq_sweep_pkg.sv
// ---------------------------------------------------------------------------
// llrf_afe_package
// Shared types and constants for the LLRF analog front-end DDS blocks.
//   sweep_mode_t  : frequency sweep behaviour at the upper bound
//   sweep_state_t : dds_freq_sweep controller states
//   DDS_FREQ_100K / DDS_FREQ_30M : tuning words for a 200 MHz DDS clock
//                                  (Freq[Hz] * 2^32 / 200e6)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package llrf_afe_package;

    typedef enum logic [1:0] {
        SW_SINGLE = 2'd0,   // ramp up once, stop at max
        SW_WRAP   = 2'd1,   // ramp up, jump back to min
        SW_BOUNCE = 2'd2    // ramp up to max, then down to min, repeat
    } sweep_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_t;

    localparam logic [31:0] DDS_FREQ_100K = 32'h0020C49B;
    localparam logic [31:0] DDS_FREQ_30M  = 32'h26666666;

    // The unused encoding 3 behaves as a single sweep.
    function automatic sweep_mode_t norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? SW_SINGLE : sweep_mode_t'(m);
    endfunction

endpackage

// File: rtl/dds_freq_sweep.sv
// ---------------------------------------------------------------------------
// dds_freq_sweep
// Frequency-ramp generator feeding dds_slave. Produces a tuning word and a
// one-cycle sync strobe for dds_slave.freq / dds_slave.synch, in the DDS clock
// domain. Sweep parameters are captured at start and held for the whole sweep.
//
// Build option: SWEEP_PROP_STEP_EN
//   defined   -> increment = freq_step + freq/65536 (proportional, log-like;
//                requires FW == 32)
//   undefined -> increment = freq_step (linear)
//
// Ports
//   clk        in   1   DDS clock
//   reset      in   1   synchronous, active-high
//   start      in   1   pulse; begins sweep when idle
//   stop       in   1   pulse; aborts sweep (wins over start)
//   mode       in   2   sweep_mode_t (3 treated as SW_SINGLE)
//   freq_min   in   FW  lower bound
//   freq_max   in   FW  upper bound
//   freq_step  in   FW  increment per update
//   interval   in   TW  clocks between updates; 0 treated as 1
//   freq       out  FW  current tuning word
//   sync       out  1   1-cycle pulse with every freq update
//   active     out  1   high while sweeping
//   ready      out  1   1-cycle pulse at sweep end / stop / reject
//   dir        out  1   0 = up, 1 = down
//   err        out  1   sticky start-reject flag (freq_min > freq_max)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module dds_freq_sweep
    import llrf_afe_package::*;
#(
    parameter int              FW           = 32,
    parameter int              TW           = 32,
    parameter logic [FW-1:0]   DEF_FREQ_MIN = FW'(DDS_FREQ_100K)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [FW-1:0] freq_min,
    input  logic [FW-1:0] freq_max,
    input  logic [FW-1:0] freq_step,
    input  logic [TW-1:0] interval,
    output logic [FW-1:0] freq,
    output logic          sync,
    output logic          active,
    output logic          ready,
    output logic          dir,
    output logic          err
);

    // ---------------- registers ----------------
    sweep_state_t  r_state;
    logic [FW-1:0] r_freq;
    logic          r_sync;
    logic          r_ready;
    logic          r_dir;
    logic          r_err;
    logic [TW-1:0] r_cnt;

    // Sweep parameters captured at an accepted start.
    sweep_mode_t   r_mode;
    logic [FW-1:0] r_min;
    logic [FW-1:0] r_max;
    logic [FW-1:0] r_step;
    logic [TW-1:0] r_reload;

    // ---------------- combinational ----------------
    sweep_state_t  w_state_nxt;
    logic          w_start_ok;
    logic          w_start_rej;
    logic [TW-1:0] w_interval_eff;
    logic          w_tick;
    logic [FW-1:0] w_inc;
    logic [FW:0]   w_nxt_up;
    logic [FW:0]   w_nxt_dn;
    logic          w_hit_top;
    logic          w_end_single;
    logic [FW-1:0] w_freq_upd;
    logic          w_dir_upd;

    // stop has priority over start in the same cycle.
    assign w_start_ok     = start && !stop && (freq_min <= freq_max);
    assign w_start_rej    = start && !stop && (freq_min >  freq_max);
    assign w_interval_eff = (interval == '0) ? TW'(1) : interval;
    assign w_tick         = (r_cnt == '0);

`ifdef SWEEP_PROP_STEP_EN
    assign w_inc = r_step + (r_freq >> 16);
`else
    assign w_inc = r_step;
`endif

    // One extra bit so a carry out (up) or borrow (down) counts as out of range.
    assign w_nxt_up     = {1'b0, r_freq} + {1'b0, w_inc};
    assign w_nxt_dn     = {1'b0, r_freq} - {1'b0, w_inc};
    assign w_hit_top    = (w_nxt_up > {1'b0, r_max});
    assign w_end_single = !r_dir && w_hit_top && (r_mode == SW_SINGLE);

    // Next tuning word and direction at an update tick.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_freq_upd = r_freq;
        w_dir_upd  = r_dir;
        if (!r_dir) begin
            if (w_hit_top) begin
                case (r_mode)
                    SW_WRAP:   w_freq_upd = r_min;
                    SW_BOUNCE: begin
                        w_freq_upd = r_max;
                        w_dir_upd  = 1'b1;
                    end
                    default:   w_freq_upd = r_max;
                endcase
            end else begin
                w_freq_upd = w_nxt_up[FW-1:0];
            end
        end else begin
            if (w_nxt_dn[FW] || (w_nxt_dn[FW-1:0] < r_min)) begin
                w_freq_upd = r_min;
                w_dir_upd  = 1'b0;
            end else begin
                w_freq_upd = w_nxt_dn[FW-1:0];
            end
        end
    end

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_state_nxt = ST_RAMP;
            ST_RAMP: begin
                if (stop)                        w_state_nxt = ST_IDLE;
                else if (w_tick && w_end_single) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    // NOTE: the captured sweep parameters have no reset; they are always
    // written before use, so resetting them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_start_ok && (r_state == ST_IDLE)) begin
            r_mode   <= norm_mode(mode);
            r_min    <= freq_min;
            r_max    <= freq_max;
            r_step   <= freq_step;
            r_reload <= w_interval_eff - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_freq  <= DEF_FREQ_MIN;
            r_sync  <= 1'b0;
            r_ready <= 1'b0;
            r_dir   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= 1'b0;
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_freq <= freq_min;
                        r_sync <= 1'b1;
                        r_dir  <= 1'b0;
                        r_err  <= 1'b0;
                        r_cnt  <= w_interval_eff - TW'(1);
                    end else if (w_start_rej) begin
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (stop) begin
                        r_ready <= 1'b1;
                    end else if (w_tick) begin
                        r_freq <= w_freq_upd;
                        r_dir  <= w_dir_upd;
                        r_sync <= 1'b1;
                        r_cnt  <= r_reload;
                    end else begin
                        r_cnt <= r_cnt - TW'(1);
                    end
                end
                ST_DONE: r_ready <= 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        freq   = r_freq;
        sync   = r_sync;
        ready  = r_ready;
        dir    = r_dir;
        err    = r_err;
        active = (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_dds_freq_sweep.sv
`timescale 1ns/1ps

module tb_dds_freq_sweep;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [31:0] freq_min;
    logic [31:0] freq_max;
    logic [31:0] freq_step;
    logic [31:0] interval;
    logic [31:0] freq;
    logic        sync;
    logic        active;
    logic        ready;
    logic        dir;
    logic        err;

    int n_checks   = 0;
    int n_failures = 0;

    always #5 clk = ~clk;

    dds_freq_sweep dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .freq_min  (freq_min),
        .freq_max  (freq_max),
        .freq_step (freq_step),
        .interval  (interval),
        .freq      (freq),
        .sync      (sync),
        .active    (active),
        .ready     (ready),
        .dir       (dir),
        .err       (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    // Wait for the next sync (bounded) and check spacing, value and direction.
    task automatic wait_sync(input string tag, input logic [31:0] exp_f,
                             input int exp_gap, input logic exp_dir);
        int n = 0;
        do begin
            step();
            n++;
        end while (!sync && n < 64);
        check({tag, "_gap"}, 64'(n), 64'(exp_gap));
        check({tag, "_freq"}, 64'(freq), 64'(exp_f));
        check({tag, "_dir"}, 64'(dir), 64'(exp_dir));
    endtask

    task automatic setup(input logic [1:0] m, input logic [31:0] mn, input logic [31:0] mx,
                         input logic [31:0] st, input logic [31:0] iv);
        mode      = m;
        freq_min  = mn;
        freq_max  = mx;
        freq_step = st;
        interval  = iv;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_sync;
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        setup(2'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // ---- 1: reset ----
        repeat (3) step();
        reset = 1'b0;
        check("rst_freq",   64'(freq),   64'h0020C49B);
        check("rst_sync",   64'(sync),   64'd0);
        check("rst_active", 64'(active), 64'd0);
        check("rst_ready",  64'(ready),  64'd0);
        check("rst_err",    64'(err),    64'd0);
        check("rst_dir",    64'(dir),    64'd0);
        step();
        check("rst_idle_freq", 64'(freq), 64'h0020C49B);

        // ---- 2: single sweep 100..130 step 10, interval 4 ----
        setup(2'd0, 32'd100, 32'd130, 32'd10, 32'd4);
        pulse_start();
        check("sg_first_freq",   64'(freq),   64'd100);
        check("sg_first_sync",   64'(sync),   64'd1);
        check("sg_first_active", 64'(active), 64'd1);
        wait_sync("sg_110", 32'd110, 4, 1'b0);
        wait_sync("sg_120", 32'd120, 4, 1'b0);
        wait_sync("sg_130", 32'd130, 4, 1'b0);
        // Reaching max exactly is in range; the next update hits the bound and ends.
        wait_sync("sg_end", 32'd130, 4, 1'b0);
        check("sg_end_active", 64'(active), 64'd1);
        check("sg_end_ready0", 64'(ready),  64'd0);
        step();
        check("sg_ready",   64'(ready),  64'd1);
        check("sg_active0", 64'(active), 64'd0);
        check("sg_hold",    64'(freq),   64'd130);
        check("sg_nosync",  64'(sync),   64'd0);
        step();
        check("sg_ready_1clk", 64'(ready), 64'd0);

        // ---- 3a: wrap, interval 0 treated as 1 ----
        setup(2'd1, 32'd0, 32'd25, 32'd10, 32'd0);
        pulse_start();
        check("wr_0", 64'(freq), 64'd0);
        wait_sync("wr_10a", 32'd10, 1, 1'b0);
        // Start while active and new bounds at the inputs must be ignored.
        freq_min = 32'd50;
        start    = 1'b1;
        wait_sync("wr_20", 32'd20, 1, 1'b0);
        start    = 1'b0;
        wait_sync("wr_0b", 32'd0, 1, 1'b0);
        wait_sync("wr_10b", 32'd10, 1, 1'b0);
        pulse_stop();
        check("wr_stop_ready", 64'(ready), 64'd1);
        check("wr_stop_active", 64'(active), 64'd0);

        // ---- 3b: bounce ----
        setup(2'd2, 32'd0, 32'd25, 32'd10, 32'd1);
        pulse_start();
        check("bn_0", 64'(freq), 64'd0);
        wait_sync("bn_10",  32'd10, 1, 1'b0);
        wait_sync("bn_20",  32'd20, 1, 1'b0);
        wait_sync("bn_25",  32'd25, 1, 1'b1);
        wait_sync("bn_15",  32'd15, 1, 1'b1);
        wait_sync("bn_5",   32'd5,  1, 1'b1);
        wait_sync("bn_0b",  32'd0,  1, 1'b0);
        wait_sync("bn_10b", 32'd10, 1, 1'b0);
        pulse_stop();

        // ---- 4: carry out of the top, mode 3 acts as single ----
        setup(2'd3, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20, 32'd2);
        pulse_start();
        check("ov_first", 64'(freq), 64'hFFFFFFF0);
        check("ov_dir_reset", 64'(dir), 64'd0);
        wait_sync("ov_max", 32'hFFFFFFFF, 2, 1'b0);
        step();
        check("ov_ready",  64'(ready),  64'd1);
        check("ov_active", 64'(active), 64'd0);
        check("ov_hold",   64'(freq),   64'hFFFFFFFF);

        // ---- 5: stop mid-ramp, start+stop, reject ----
        setup(2'd0, 32'd100, 32'd130, 32'd10, 32'd4);
        pulse_start();
        wait_sync("st_110", 32'd110, 4, 1'b0);
        wait_sync("st_120", 32'd120, 4, 1'b0);
        step();
        pulse_stop();
        check("st_ready",  64'(ready),  64'd1);
        check("st_active", 64'(active), 64'd0);
        check("st_freq",   64'(freq),   64'd120);
        check("st_sync",   64'(sync),   64'd0);
        n_sync = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (sync) n_sync++;
        end
        check("st_no_sync_after", 64'(n_sync), 64'd0);
        check("st_freq_held", 64'(freq), 64'd120);

        pulse_stop();   // stop while idle: no effect
        check("st_idle_stop_ready", 64'(ready), 64'd0);

        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_active", 64'(active), 64'd0);
        check("ss_sync",   64'(sync),   64'd0);
        check("ss_freq",   64'(freq),   64'd120);
        step();
        check("ss_active2", 64'(active), 64'd0);

        setup(2'd0, 32'd200, 32'd100, 32'd10, 32'd1);
        pulse_start();
        check("rj_err",    64'(err),    64'd1);
        check("rj_ready",  64'(ready),  64'd1);
        check("rj_active", 64'(active), 64'd0);
        check("rj_freq",   64'(freq),   64'd120);
        step();
        check("rj_err_sticky", 64'(err),   64'd1);
        check("rj_ready_1clk", 64'(ready), 64'd0);

        setup(2'd1, 32'd0, 32'd25, 32'd10, 32'd1);
        pulse_start();
        check("rj_err_clear", 64'(err),  64'd0);
        check("rj_restart",   64'(freq), 64'd0);
        pulse_stop();

        // ---- 6: zero step (proportional increment when enabled) ----
        setup(2'd0, 32'h00010000, 32'hFFFFFFFF, 32'd0, 32'd1);
        pulse_start();
        check("p_first", 64'(freq), 64'h10000);
`ifdef SWEEP_PROP_STEP_EN
        wait_sync("p_1", 32'h10001, 1, 1'b0);
        wait_sync("p_2", 32'h10002, 1, 1'b0);
`else
        wait_sync("p_1", 32'h10000, 1, 1'b0);
        wait_sync("p_2", 32'h10000, 1, 1'b0);
`endif
        check("p_active", 64'(active), 64'd1);

        // ---- reset mid-sweep ----
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rm_freq",   64'(freq),   64'h0020C49B);
        check("rm_active", 64'(active), 64'd0);
        check("rm_sync",   64'(sync),   64'd0);
        check("rm_ready",  64'(ready),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
